downlink_seq: RTL
=================

# downlink_seq

Downlink telemetry sequencer for I/O channels 34/35. It captures software writes to channels 34 and 35 into double-buffered holding registers. On each word-start strobe it assembles a 40-bit telemetry frame and shifts it out serially on the bit-rate strobe. When a frame completes it raises a one-cycle DOWNRUPT request so software can refill the channels. It sits beside the channel I/O decode logic and consumes its WCH34_n/WCH35_n write strobes and the write-bus data.

## Interface
Parameters:
- SYNC, 3'b101: start pattern, sent first (MSB first).
- STOP, 4'b0000: trailer pattern, sent last.

Ports:
- SIM_CLK  in  1  simulation/system clock; all state is on its rising edge.
- SIM_RST  in  1  reset, asynchronous, active-high.
- GOJAM  in  1  synchronous hardware restart; same effect as reset, applied at the next edge.
- WCH34_n  in  1  active-low write strobe for channel 34; one cycle wide.
- WCH35_n  in  1  active-low write strobe for channel 35; one cycle wide.
- WL  in  16  write-bus data, bits WL01..WL14 and WL16; bit 14 is unused and ignored.
- WORDORD  in  1  word-order bit, sampled at frame load.
- WORDSTB  in  1  one-cycle word-start strobe (50 Hz class).
- BITSTB  in  1  one-cycle bit strobe (51.2 kHz class).
- DLKDAT  out  1  serial downlink data.
- DLKGATE  out  1  high while a frame is on DLKDAT.
- DOWNRUPT  out  1  one-cycle interrupt request at frame end.
- DLKOVR  out  1  sticky overrun flag; cleared only by reset or GOJAM.

## Operation
- Holding registers:
  - H34 and H35 are 16 bits each. A write strobe low loads the register from WL.
  - A WCH35_n write also sets PEND.
  - Writes are accepted in every state. Writes during SHIFT never disturb the frame in flight.
- Frame layout, 40 bits, MSB first: SYNC[2:0], WORDORD, H34[15:0], H35[15:0], STOP[3:0].
- States:
  - IDLE: DLKGATE=0, DLKDAT=0. WORDSTB with PEND=1 loads the shifter from H34/H35/WORDORD, clears PEND, resets the bit counter to 0, and moves to SHIFT. WORDSTB with PEND=0 is ignored.
  - SHIFT: DLKGATE=1 and DLKDAT = current MSB. Each BITSTB shifts left one bit and increments the counter. The BITSTB that makes the count 40 moves to END.
  - END: DOWNRUPT=1 for exactly one cycle, DLKGATE=0, then IDLE.
- WORDSTB in SHIFT or END sets DLKOVR and is otherwise ignored. It does not restart the frame and does not clear PEND.
- Simultaneous events:
  - WCH35_n write in the same cycle as a loading WORDSTB: the frame uses the old H35, and PEND remains set from the new write, so the next WORDSTB sends the new data.
  - WORDSTB and BITSTB in the same cycle in IDLE: load only, no shift.
  - WCH34_n and WCH35_n together: both load.
- GOJAM or SIM_RST mid-frame aborts immediately: IDLE, shifter and counter cleared, PEND=0, H34=H35=0, DLKOVR=0. No DOWNRUPT is issued.

## Timing
- Reset values: DLKDAT=0, DLKGATE=0, DOWNRUPT=0, DLKOVR=0. Internally, state=IDLE, PEND=0, H34=H35=0.
- Write strobe sampled at edge N: the holding register and PEND are valid at N+1.
- WORDSTB sampled at edge N (IDLE, PEND=1): DLKGATE=1 and DLKDAT=SYNC[2] from N+1.
- Bit k, for k = 0..39, is held from the cycle after the k-th BITSTB until the next BITSTB.
- The 40th BITSTB at edge M: DOWNRUPT=1 during cycle M+1. The machine returns to IDLE at M+2.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package dlk_pkg holds:
  - the state enum {IDLE, SHIFT, END};
  - FRAME_BITS=40;
  - default SYNC/STOP constants;
  - the bit-counter width (6).
- Sub-module dlk_shifter: a 40-bit parallel-load, serial-out shift register with a 6-bit counter and a done output. The top level holds the holding registers, PEND, the FSM and DLKOVR.

## Test plan
- Basic frame: write H34=16'hA5C3 then H35=16'h0F0F, WORDORD=1, then WORDSTB.
  - Expect DLKDAT to sequence 1,0,1,1, then A5C3 MSB-first, then 0F0F, then 0000 over 40 BITSTBs.
  - Expect one DOWNRUPT pulse, and DLKGATE high exactly during the frame.
- No pending: WORDSTB with PEND=0 → stays IDLE, DLKGATE=0, no DOWNRUPT.
- Double buffering:
  - Write H35=16'h1234 during bit 20 of a frame → the current frame still carries the old H35.
  - The next WORDSTB sends 1234.
- Overrun: WORDSTB during SHIFT → DLKOVR=1 and stays 1. The frame completes unchanged with a single DOWNRUPT.
- Abort:
  - Assert GOJAM at bit 17 → next cycle DLKGATE=0, DLKDAT=0, DLKOVR=0, and no DOWNRUPT.
  - A following WORDSTB does nothing until H35 is rewritten.
  - Repeat the same scenario with async SIM_RST asserted mid-cycle; the outputs clear without waiting for an edge.
- Coincidence:
  - WCH35_n write in the same cycle as a loading WORDSTB → frame has the old H35 and PEND=1 afterwards.
  - WORDSTB+BITSTB together in IDLE → first bit still SYNC[2].

Source files
------------

// File: rtl/dlk_pkg.sv
// Shared types and constants for the channel 34/35 downlink telemetry sequencer.
package dlk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    END   = 2'd2
  } dlk_state_t;

  localparam int FRAME_BITS = 40;
  localparam int CNT_W      = 6;

  localparam logic [2:0]  SYNC_DEF = 3'b101;
  localparam logic [3:0]  STOP_DEF = 4'b0000;
  // WL bit 14 carries no data on these channels
  localparam logic [15:0] WL_MASK  = 16'hBFFF;

  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic [2:0]  sync,
    input logic        word_ord,
    input logic [15:0] h34,
    input logic [15:0] h35,
    input logic [3:0]  stop
  );
    return {sync, word_ord, h34, h35, stop};
  endfunction

endpackage

// File: rtl/dlk_shifter.sv
// 40-bit parallel-load, MSB-first serial shifter with a bit counter.
// o_done flags that the bit now on the line is the last one of the frame.
module dlk_shifter
  import dlk_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [FRAME_BITS-1:0] i_data,
  output logic                  o_msb,
  output logic                  o_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] r_sreg;
  logic [CNT_W-1:0]      r_cnt;

  // Shift register and counter; load has priority over shift
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_sreg <= {r_sreg[FRAME_BITS-2:0], 1'b0};
      r_cnt  <= r_cnt + 6'd1;
    end
  end

  assign o_msb  = r_sreg[FRAME_BITS-1];
  assign o_done = (r_cnt == LAST_IDX);

endmodule

// File: rtl/downlink_seq.sv
// Downlink telemetry sequencer: double-buffered channel 34/35 holding registers,
// frame FSM, overrun flag and end-of-frame DOWNRUPT request.
module downlink_seq
  import dlk_pkg::*;
#(
  parameter logic [2:0] SYNC = SYNC_DEF,
  parameter logic [3:0] STOP = STOP_DEF
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        GOJAM,
  input  logic        WCH34_n,
  input  logic        WCH35_n,
  input  logic [15:0] WL,
  input  logic        WORDORD,
  input  logic        WORDSTB,
  input  logic        BITSTB,
  output logic        DLKDAT,
  output logic        DLKGATE,
  output logic        DOWNRUPT,
  output logic        DLKOVR
);

  dlk_state_t r_state;
  dlk_state_t w_state_nxt;

  logic [15:0] r_h34;
  logic [15:0] r_h35;
  logic        r_pend;
  logic        r_gate;
  logic        r_rupt;
  logic        r_ovr;

  logic                  w_load;
  logic                  w_shift;
  logic                  w_done;
  logic                  w_msb;
  logic                  w_gate_nxt;
  logic                  w_rupt_nxt;
  logic                  w_ovr_set;
  logic [FRAME_BITS-1:0] w_frame;

  assign w_frame = build_frame(SYNC, WORDORD, r_h34, r_h35, STOP);

  // State register
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_state <= IDLE;
    end else if (GOJAM) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = (WORDSTB && r_pend) ? SHIFT : IDLE;
      SHIFT:   w_state_nxt = (BITSTB && w_done) ? END : SHIFT;
      END:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM control strobes and next values of the registered outputs
  always_comb begin
    w_load     = (r_state == IDLE) && WORDSTB && r_pend;
    w_shift    = (r_state == SHIFT) && BITSTB;
    w_ovr_set  = WORDSTB && (r_state != IDLE);
    w_gate_nxt = (w_state_nxt == SHIFT);
    w_rupt_nxt = (w_state_nxt == END);
  end

  // Holding registers and PEND; a new channel 35 write wins over the load clearing PEND
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_h34  <= 16'h0000;
      r_h35  <= 16'h0000;
      r_pend <= 1'b0;
    end else if (GOJAM) begin
      r_h34  <= 16'h0000;
      r_h35  <= 16'h0000;
      r_pend <= 1'b0;
    end else begin
      if (!WCH34_n) r_h34 <= WL & WL_MASK;
      if (!WCH35_n) r_h35 <= WL & WL_MASK;
      if (!WCH35_n)   r_pend <= 1'b1;
      else if (w_load) r_pend <= 1'b0;
    end
  end

  // Registered gate, interrupt request and sticky overrun
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      r_gate <= 1'b0;
      r_rupt <= 1'b0;
      r_ovr  <= 1'b0;
    end else if (GOJAM) begin
      r_gate <= 1'b0;
      r_rupt <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_gate <= w_gate_nxt;
      r_rupt <= w_rupt_nxt;
      r_ovr  <= r_ovr | w_ovr_set;
    end
  end

  dlk_shifter u_shifter (
    .i_clk   (SIM_CLK),
    .i_rst   (SIM_RST),
    .i_clr   (GOJAM),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_frame),
    .o_msb   (w_msb),
    .o_done  (w_done)
  );

  assign DLKDAT   = w_msb;
  assign DLKGATE  = r_gate;
  assign DOWNRUPT = r_rupt;
  assign DLKOVR   = r_ovr;

endmodule
